// File: rtl/touch_ctrl_grid.sv
// touch_ctrl_grid: debounced touch-panel decoder that turns raw coordinates into
// grid-cell taps and a slider value with auto-repeating -/+ buttons.
module touch_ctrl_grid #(
    parameter int CW        = 8,
    parameter int X_OFF     = 7,
    parameter int Y_OFF     = 7,
    parameter int CELL_W    = 19,
    parameter int CELL_H    = 8,
    parameter int COLS      = 12,
    parameter int ROWS      = 16,
    parameter int SL_Y0     = 155,
    parameter int SL_Y1     = 168,
    parameter int MINUS_X0  = 20,
    parameter int SL_X0     = 40,
    parameter int SL_X1     = 220,
    parameter int PLUS_X1   = 240,
    parameter int SLIDE_MAX = 127,
    parameter int DEB       = 3,
    parameter int DRAG_X    = 3,
    parameter int DRAG_Y    = 9,
    parameter int REP_DLY   = 8,
    parameter int REP_PER   = 2,
    localparam int COL_W    = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic             sys_clk,
    input  logic             iRST_n,
    input  logic [CW-1:0]    x,
    input  logic [CW-1:0]    y,
    input  logic             new_coord_r,
    input  logic             penirq_n,
    input  logic             load_en,
    input  logic [7:0]       load_val,
    output logic             pen_down,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             cell_hit,
    output logic             drag,
    output logic [7:0]       slide_val,
    output logic             write_slide,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_PRESSED  = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        R_NONE   = 3'd0,
        R_TEXT   = 3'd1,
        R_MINUS  = 3'd2,
        R_SLIDER = 3'd3,
        R_PLUS   = 3'd4
    } region_t;

    state_t           state;
    state_t           state_next;
    region_t          region_q;
    region_t          region_now;
    region_t          act_region;
    logic             pen_s1;
    logic             pen_s2;
    logic             pen;
    logic [CW-1:0]    hit_x;
    logic [CW-1:0]    hit_y;
    logic [7:0]       deb_cnt;
    logic [7:0]       rep_cnt;
    logic             rep_first;
    logic             deb_clr;
    logic             press_evt;
    logic             pressed_strobe;
    logic             release_evt;
    logic             rep_fire;
    logic             drag_now;
    logic             touch_upd;
    logic [7:0]       touch_val;
    logic [7:0]       load_clamped;
    logic [COL_W-1:0] tap_col;
    logic [ROW_W-1:0] tap_row;

    function automatic region_t region_of(input int px, input int py);
        region_t r;
        r = R_NONE;
        if (px >= X_OFF && py >= Y_OFF &&
            (px - X_OFF) / CELL_W < COLS && (py - Y_OFF) / CELL_H < ROWS) begin
            r = R_TEXT;
        end else if (py >= SL_Y0 && py <= SL_Y1) begin
            if (px >= MINUS_X0 && px < SL_X0)     r = R_MINUS;
            else if (px >= SL_X0 && px <= SL_X1)  r = R_SLIDER;
            else if (px > SL_X1 && px <= PLUS_X1) r = R_PLUS;
        end
        return r;
    endfunction

    function automatic int slider_of(input int px);
        int cx;
        cx = px;
        if (cx < SL_X0) cx = SL_X0;
        if (cx > SL_X1) cx = SL_X1;
        return ((cx - SL_X0) * SLIDE_MAX) / (SL_X1 - SL_X0);
    endfunction

    function automatic int absdiff(input int a, input int b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // penirq_n is asynchronous; idle level of the synchroniser is "pen up".
    always_ff @(posedge sys_clk or negedge iRST_n) begin
        if (!iRST_n) begin
            pen_s1 <= 1'b1;
            pen_s2 <= 1'b1;
        end else begin
            pen_s1 <= penirq_n;
            pen_s2 <= pen_s1;
        end
    end

    assign pen = ~pen_s2;

    always_ff @(posedge sys_clk or negedge iRST_n) begin
        if (!iRST_n) state <= S_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next     = state;
        deb_clr        = 1'b0;
        press_evt      = 1'b0;
        pressed_strobe = 1'b0;
        release_evt    = 1'b0;
        case (state)
            S_IDLE: begin
                if (pen) begin
                    deb_clr    = 1'b1;
                    state_next = S_DEBOUNCE;
                end
            end
            S_DEBOUNCE: begin
                if (!pen) begin
                    state_next = S_IDLE;
                end else if (new_coord_r && (int'(deb_cnt) + 1 >= DEB)) begin
                    press_evt  = 1'b1;
                    state_next = S_PRESSED;
                end
            end
            S_PRESSED: begin
                if (!pen) begin
                    release_evt = 1'b1;
                    state_next  = S_RELEASE;
                end else if (new_coord_r) begin
                    pressed_strobe = 1'b1;
                end
            end
            S_RELEASE: state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    assign fsm_state    = state;
    assign region_now   = region_of(int'(x), int'(y));
    // At the press the latched region is not yet valid, so classify live.
    assign act_region   = (state == S_DEBOUNCE) ? region_now : region_q;
    assign drag_now     = (absdiff(int'(x), int'(hit_x)) > DRAG_X) ||
                          (absdiff(int'(y), int'(hit_y)) > DRAG_Y);
    assign rep_fire     = pressed_strobe &&
                          (int'(rep_cnt) + 1 >= (rep_first ? REP_DLY : REP_PER));
    assign tap_col      = COL_W'((int'(hit_x) - X_OFF) / CELL_W);
    assign tap_row      = ROW_W'((int'(hit_y) - Y_OFF) / CELL_H);
    assign load_clamped = (int'(load_val) > SLIDE_MAX) ? 8'(SLIDE_MAX) : load_val;

    always_comb begin
        touch_upd = 1'b0;
        touch_val = slide_val;
        if (press_evt || pressed_strobe) begin
            case (act_region)
                R_SLIDER: begin
                    touch_upd = 1'b1;
                    touch_val = 8'(slider_of(int'(x)));
                end
                R_MINUS: begin
                    if (press_evt || rep_fire) begin
                        touch_upd = 1'b1;
                        touch_val = (slide_val == 8'd0) ? slide_val : slide_val - 8'd1;
                    end
                end
                R_PLUS: begin
                    if (press_evt || rep_fire) begin
                        touch_upd = 1'b1;
                        touch_val = (int'(slide_val) >= SLIDE_MAX) ? slide_val
                                                                    : slide_val + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge iRST_n) begin
        if (!iRST_n) begin
            hit_x       <= '0;
            hit_y       <= '0;
            region_q    <= R_NONE;
            deb_cnt     <= '0;
            rep_cnt     <= '0;
            rep_first   <= 1'b0;
            pen_down    <= 1'b0;
            drag        <= 1'b0;
            col         <= '0;
            row         <= '0;
            cell_hit    <= 1'b0;
            slide_val   <= '0;
            write_slide <= 1'b0;
        end else begin
            cell_hit    <= 1'b0;
            write_slide <= 1'b0;

            if (deb_clr) begin
                deb_cnt <= '0;
            end else if (state == S_DEBOUNCE && pen && new_coord_r) begin
                deb_cnt <= deb_cnt + 8'd1;
            end

            if (press_evt) begin
                hit_x     <= x;
                hit_y     <= y;
                region_q  <= region_now;
                pen_down  <= 1'b1;
                drag      <= 1'b0;
                rep_cnt   <= '0;
                rep_first <= 1'b1;
            end else if (pressed_strobe) begin
                if (drag_now) drag <= 1'b1;
                if (rep_fire) begin
                    rep_cnt   <= '0;
                    rep_first <= 1'b0;
                end else begin
                    rep_cnt <= rep_cnt + 8'd1;
                end
            end

            // Cell taps report on the cycle the FSM sits in RELEASE.
            if (release_evt) begin
                pen_down <= 1'b0;
                if (region_q == R_TEXT && !drag) begin
                    cell_hit <= 1'b1;
                    col      <= tap_col;
                    row      <= tap_row;
                end
            end

            if (load_en) begin
                slide_val <= load_clamped;
            end else if (touch_upd && touch_val != slide_val) begin
                slide_val   <= touch_val;
                write_slide <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_touch_ctrl_grid.sv
// Bench for touch_ctrl_grid: directed scenarios plus randomized presses checked
// against a coordinate-level reference model through expected-event queues.
module tb_touch_ctrl_grid;

    localparam int X_OFF = 7, Y_OFF = 7, CELL_W = 19, CELL_H = 8, COLS = 12, ROWS = 16;
    localparam int SL_Y0 = 155, SL_Y1 = 168, MINUS_X0 = 20, SL_X0 = 40, SL_X1 = 220;
    localparam int PLUS_X1 = 240, SLIDE_MAX = 127, DEB = 3, DRAG_X = 3, DRAG_Y = 9;
    localparam int REP_DLY = 8, REP_PER = 2;
    localparam int RG_NONE = 0, RG_TEXT = 1, RG_MINUS = 2, RG_SLIDER = 3, RG_PLUS = 4;

    logic       sys_clk = 1'b0;
    logic       iRST_n = 1'b0;
    logic [7:0] x = '0;
    logic [7:0] y = '0;
    logic       new_coord_r = 1'b0;
    logic       penirq_n = 1'b1;
    logic       load_en = 1'b0;
    logic [7:0] load_val = '0;
    logic       pen_down;
    logic [3:0] col;
    logic [3:0] row;
    logic       cell_hit;
    logic       drag;
    logic [7:0] slide_val;
    logic       write_slide;
    logic [1:0] fsm_state;

    touch_ctrl_grid dut (
        .sys_clk    (sys_clk),
        .iRST_n     (iRST_n),
        .x          (x),
        .y          (y),
        .new_coord_r(new_coord_r),
        .penirq_n   (penirq_n),
        .load_en    (load_en),
        .load_val   (load_val),
        .pen_down   (pen_down),
        .col        (col),
        .row        (row),
        .cell_hit   (cell_hit),
        .drag       (drag),
        .slide_val  (slide_val),
        .write_slide(write_slide),
        .fsm_state  (fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 sys_clk = ~sys_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];      // expected slide_val on each write_slide pulse
    logic [7:0] exp_hit_q[$];  // expected {col,row} on each cell_hit pulse
    logic       saw_pen_down = 1'b0;

    // reference model state
    int m_slide = 0, m_region = 0, m_hit_x = 0, m_hit_y = 0, m_drag = 0, m_k = 0;
    int m_col = 0, m_row = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge sys_clk) begin
        if (iRST_n) begin
            if (pen_down) saw_pen_down = 1'b1;
            if (write_slide) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL write_slide_unexpected: pulse with slide_val=%0d, none expected",
                             slide_val);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check("write_slide_val", int'(slide_val), int'(e));
                end
            end
            if (cell_hit) begin
                if (exp_hit_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cell_hit_unexpected: pulse col=%0d row=%0d, none expected",
                             col, row);
                end else begin
                    logic [7:0] e;
                    e = exp_hit_q.pop_front();
                    check("cell_hit_col", int'(col), int'(e[7:4]));
                    check("cell_hit_row", int'(row), int'(e[3:0]));
                end
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic int m_region_of(input int px, input int py);
        if (px >= X_OFF && py >= Y_OFF && (px - X_OFF) / CELL_W < COLS &&
            (py - Y_OFF) / CELL_H < ROWS) return RG_TEXT;
        if (py < SL_Y0 || py > SL_Y1) return RG_NONE;
        if (px >= MINUS_X0 && px <= SL_X0 - 1) return RG_MINUS;
        if (px >= SL_X0 && px <= SL_X1) return RG_SLIDER;
        if (px >= SL_X1 + 1 && px <= PLUS_X1) return RG_PLUS;
        return RG_NONE;
    endfunction

    function automatic int m_slider(input int px);
        int cx;
        cx = (px < SL_X0) ? SL_X0 : ((px > SL_X1) ? SL_X1 : px);
        return ((cx - SL_X0) * SLIDE_MAX) / (SL_X1 - SL_X0);
    endfunction

    function automatic int m_step(input int v, input int dir);
        int n;
        n = v + dir;
        if (n < 0) n = 0;
        if (n > SLIDE_MAX) n = SLIDE_MAX;
        return n;
    endfunction

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic model_apply(input int nv, input bit with_load, input int lv);
        if (with_load) begin
            m_slide = (lv > SLIDE_MAX) ? SLIDE_MAX : lv;
        end else if (nv != m_slide) begin
            m_slide = nv;
            exp_q.push_back(8'(nv));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic send_strobe(input int px, input int py, input bit with_load, input int lv);
        x           = 8'(px);
        y           = 8'(py);
        new_coord_r = 1'b1;
        load_en     = with_load;
        load_val    = 8'(lv);
        tick(1);
        new_coord_r = 1'b0;
        load_en     = 1'b0;
    endtask

    task automatic do_load(input int lv);
        load_en  = 1'b1;
        load_val = 8'(lv);
        tick(1);
        load_en  = 1'b0;
        m_slide  = (lv > SLIDE_MAX) ? SLIDE_MAX : lv;
        tick(1);
        check("load_value", int'(slide_val), m_slide);
    endtask

    task automatic press_at(input int px, input int py);
        int nv;
        penirq_n = 1'b0;
        tick(4);
        for (int i = 1; i <= DEB; i++) begin
            send_strobe(px, py, 1'b0, 0);
            if (i < DEB) check("pen_down_debouncing", int'(pen_down), 0);
        end
        m_hit_x  = px;
        m_hit_y  = py;
        m_region = m_region_of(px, py);
        m_drag   = 0;
        m_k      = 0;
        nv       = m_slide;
        if (m_region == RG_SLIDER)     nv = m_slider(px);
        else if (m_region == RG_MINUS) nv = m_step(m_slide, -1);
        else if (m_region == RG_PLUS)  nv = m_step(m_slide, 1);
        model_apply(nv, 1'b0, 0);
        tick(1);
        check("pen_down_pressed", int'(pen_down), 1);
        check("drag_at_press", int'(drag), 0);
        check("slide_after_press", int'(slide_val), m_slide);
        check("press_ws_pending", exp_q.size(), 0);
    endtask

    task automatic move_to(input int px, input int py, input bit with_load, input int lv);
        int nv;
        send_strobe(px, py, with_load, lv);
        m_k++;
        if (absd(px, m_hit_x) > DRAG_X || absd(py, m_hit_y) > DRAG_Y) m_drag = 1;
        nv = m_slide;
        if (m_region == RG_SLIDER) begin
            nv = m_slider(px);
        end else if (m_region == RG_MINUS || m_region == RG_PLUS) begin
            if (m_k == REP_DLY || (m_k > REP_DLY && (m_k - REP_DLY) % REP_PER == 0))
                nv = m_step(m_slide, (m_region == RG_PLUS) ? 1 : -1);
        end
        model_apply(nv, with_load, lv);
        tick(1);
        check("slide_after_move", int'(slide_val), m_slide);
        check("drag_after_move", int'(drag), m_drag);
        check("move_ws_pending", exp_q.size(), 0);
    endtask

    task automatic release_pen();
        penirq_n = 1'b1;
        if (m_region == RG_TEXT && m_drag == 0) begin
            m_col = (m_hit_x - X_OFF) / CELL_W;
            m_row = (m_hit_y - Y_OFF) / CELL_H;
            exp_hit_q.push_back(8'((m_col << 4) | m_row));
        end
        tick(6);
        check("pen_down_released", int'(pen_down), 0);
        check("hit_missing", exp_hit_q.size(), 0);
        check("state_after_release", int'(fsm_state), 0);
        check("drag_hold", int'(drag), m_drag);
        check("col_hold", int'(col), m_col);
        check("row_hold", int'(row), m_row);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pen_down"}, int'(pen_down), 0);
        check({tag, "_col"}, int'(col), 0);
        check({tag, "_row"}, int'(row), 0);
        check({tag, "_cell_hit"}, int'(cell_hit), 0);
        check({tag, "_drag"}, int'(drag), 0);
        check({tag, "_slide_val"}, int'(slide_val), 0);
        check({tag, "_write_slide"}, int'(write_slide), 0);
        check({tag, "_state"}, int'(fsm_state), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int px, py, kind, nmoves, mx, my;

        tick(3);
        check_all_zero("reset");
        iRST_n = 1'b1;
        tick(3);

        // tap on a text cell
        press_at(45, 30);
        release_pen();
        check("tap_col", int'(col), 2);
        check("tap_row", int'(row), 2);
        check("tap_drag", int'(drag), 0);

        // drag rejects the tap and leaves col/row alone
        press_at(100, 60);
        move_to(105, 60, 1'b0, 0);
        check("drag_set", int'(drag), 1);
        release_pen();
        check("drag_col_kept", int'(col), 2);
        check("drag_row_kept", int'(row), 2);

        // bounce: fewer than DEB strobes
        saw_pen_down = 1'b0;
        penirq_n = 1'b0;
        tick(4);
        for (int i = 1; i < DEB; i++) send_strobe(45, 30, 1'b0, 0);
        penirq_n = 1'b1;
        tick(6);
        check("bounce_pen_down", int'(saw_pen_down), 0);
        check("bounce_state", int'(fsm_state), 0);
        check("bounce_slide", int'(slide_val), m_slide);

        // slider with clamping at both ends
        press_at(130, 160);
        check("slider_press", int'(slide_val), 63);
        move_to(250, 160, 1'b0, 0);
        check("slider_right", int'(slide_val), 127);
        move_to(10, 160, 1'b0, 0);
        check("slider_left", int'(slide_val), 0);
        release_pen();

        // auto-repeat on + with saturation
        do_load(125);
        press_at(230, 160);
        check("rep_first", int'(slide_val), 126);
        for (int i = 0; i < REP_DLY; i++) move_to(230, 160, 1'b0, 0);
        check("rep_second", int'(slide_val), 127);
        move_to(230, 160, 1'b0, 0);
        check("rep_saturated", int'(slide_val), 127);
        release_pen();

        // load wins over a + step in the same cycle
        do_load(50);
        press_at(230, 160);
        check("load_press", int'(slide_val), 51);
        for (int i = 1; i < REP_DLY; i++) move_to(230, 160, 1'b0, 0);
        move_to(230, 160, 1'b1, 200);
        check("load_priority", int'(slide_val), 127);
        move_to(230, 160, 1'b0, 0);
        move_to(230, 160, 1'b0, 0);
        release_pen();

        // minus button saturates at zero
        do_load(1);
        press_at(25, 160);
        check("minus_press", int'(slide_val), 0);
        for (int i = 0; i < REP_DLY + 2; i++) move_to(25, 160, 1'b0, 0);
        release_pen();

        // reset in the middle of a press
        press_at(130, 160);
        iRST_n = 1'b0;
        #1;
        check_all_zero("midreset");
        penirq_n = 1'b1;
        exp_q.delete();
        exp_hit_q.delete();
        m_slide = 0; m_col = 0; m_row = 0; m_drag = 0; m_region = RG_NONE;
        tick(3);
        iRST_n = 1'b1;
        tick(3);
        check("post_reset_state", int'(fsm_state), 0);

        // randomized presses
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) do_load(int'($urandom_range(0, 255)));
            kind = int'($urandom_range(0, 3));
            case (kind)
                0: begin
                    px = int'($urandom_range(X_OFF, X_OFF + COLS * CELL_W - 1));
                    py = int'($urandom_range(Y_OFF, Y_OFF + ROWS * CELL_H - 1));
                end
                1: begin
                    px = int'($urandom_range(0, 255));
                    py = int'($urandom_range(SL_Y0, SL_Y1));
                end
                2: begin
                    px = ($urandom_range(0, 1) == 0) ? int'($urandom_range(MINUS_X0, SL_X0 - 1))
                                                     : int'($urandom_range(SL_X1 + 1, PLUS_X1));
                    py = int'($urandom_range(SL_Y0, SL_Y1));
                end
                default: begin
                    px = int'($urandom_range(0, 255));
                    py = int'($urandom_range(0, 255));
                end
            endcase
            press_at(px, py);
            nmoves = int'($urandom_range(0, 14));
            mx = px;
            my = py;
            for (int j = 0; j < nmoves; j++) begin
                mx = px + int'($urandom_range(0, 8)) - 4;
                my = py + int'($urandom_range(0, 24)) - 12;
                if (kind == 1 && $urandom_range(0, 3) == 0) mx = int'($urandom_range(0, 255));
                if (mx < 0) mx = 0;
                if (mx > 255) mx = 255;
                if (my < 0) my = 0;
                if (my > 255) my = 255;
                move_to(mx, my, 1'b0, 0);
            end
            release_pen();
        end

        tick(4);
        check("final_ws_queue", exp_q.size(), 0);
        check("final_hit_queue", exp_hit_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/touch_ctrl_grid.md
# touch_ctrl_grid

Parametrised, fully synchronous successor to the board touch-panel decoder: turns raw panel coordinates and pen interrupt into debounced press/release events, a text-grid cell selection, and a slider value with −/+ buttons. Grid geometry, slider geometry, value range, debounce depth and drag tolerance are parameters. The block adds drag rejection and auto-repeat on the −/+ buttons. It sits between the touch ADC front end (which supplies `x`, `y`, `new_coord_r`) and the parameter-edit / display logic.

## Interface
- CW, 8, coordinate width
- X_OFF / Y_OFF, 7 / 7, grid origin
- CELL_W / CELL_H, 19 / 8, cell size in coordinate units
- COLS / ROWS, 12 / 16, grid dimensions
- SL_Y0 / SL_Y1, 155 / 168, slider row y-range, inclusive
- MINUS_X0, 20, left edge of − button; the − button spans MINUS_X0..SL_X0−1
- SL_X0 / SL_X1, 40 / 220, slider bar x-range, inclusive
- PLUS_X1, 240, right edge of + button; the + button spans SL_X1+1..PLUS_X1
- SLIDE_MAX, 127, top of the slider value range
- DEB, 3, consecutive pen-down samples needed to accept a press
- DRAG_X / DRAG_Y, 3 / 9, maximum |delta| from the hit point still counted as a tap
- REP_DLY / REP_PER, 8 / 2, auto-repeat delay and period, counted in samples
- sys_clk  in  1  system clock
- iRST_n  in  1  asynchronous active-low reset
- x, y  in  CW  current coordinate; valid when `new_coord_r`=1
- new_coord_r  in  1  one-cycle sample strobe
- penirq_n  in  1  pen-down, active low, asynchronous to `sys_clk`
- load_en  in  1  load `slide_val` from `load_val`
- load_val  in  8  external value (e.g. the character being edited)
- pen_down  out  1  debounced pen state
- col  out  $clog2(COLS)  selected column
- row  out  $clog2(ROWS)  selected row
- cell_hit  out  1  one-cycle pulse: tap accepted on a grid cell
- drag  out  1  current press has exceeded the drag tolerance
- slide_val  out  8  slider value, range 0..SLIDE_MAX
- write_slide  out  1  one-cycle pulse: `slide_val` changed by touch

## Operation
- `penirq_n` passes through a 2-flop synchroniser; `pen` is the inverted synchronised value.
- **Reset** (async, iRST_n=0): FSM→IDLE; all outputs 0; hit_x, hit_y and all counters 0.
- **FSM states:**
  - **IDLE:** if `pen`, clear the debounce count and go to DEBOUNCE.
  - **DEBOUNCE:**
    - If `pen`=0, go to IDLE; no event is generated.
    - Each strobe increments the debounce count.
    - On the DEB-th strobe: latch hit_x/hit_y ← x/y, classify the region, set `pen_down`, clear `drag`, go to PRESSED.
  - **PRESSED:**
    - Each strobe compares |x−hit_x| > DRAG_X or |y−hit_y| > DRAG_Y; if true, `drag` is set and stays set.
    - If `pen`=0, go to RELEASE.
  - **RELEASE** (one cycle):
    - If region=TEXT and `drag`=0, set col/row and pulse `cell_hit`.
    - Clear `pen_down` and go to IDLE. `drag` holds until the next press.
- **Regions** are evaluated once, on the latched hit point. The first match wins, in this order:
  - **TEXT:** x≥X_OFF, y≥Y_OFF, (x−X_OFF)/CELL_W < COLS, (y−Y_OFF)/CELL_H < ROWS.
  - **MINUS, SLIDER, PLUS:** y in SL_Y0..SL_Y1, with x in the ranges given under Interface.
  - **NONE:** otherwise.
- **col/row:** integer quotients as above, registered; they hold their value until the next accepted tap.
- **SLIDER:**
  - On the press and on every strobe in PRESSED, compute s = ((clamp(x, SL_X0, SL_X1) − SL_X0) · SLIDE_MAX) / (SL_X1 − SL_X0), truncated.
  - If s ≠ slide_val: `slide_val`←s and `write_slide` pulses.
  - The region is fixed at the press, so dragging off the bar clamps s rather than exiting the slider.
- **MINUS/PLUS:**
  - One step (±1) on entry to PRESSED.
  - After REP_DLY further strobes, one more step; then one step every REP_PER strobes while still pressed.
  - Values saturate at 0 and SLIDE_MAX. A saturated step does not change the value and does not pulse `write_slide`.
- **load_en** has priority over any touch update in the same cycle. That cycle's touch step is discarded and `write_slide` is not pulsed. load_val>SLIDE_MAX is clamped to SLIDE_MAX.
- A strobe is not required for release; release is detected from `pen` alone.

## Timing
- **Press:** `pen_down` and the first slider/step update are registered 1 cycle after the DEB-th strobe. `write_slide` is asserted in the same cycle that `slide_val` changes.
- **Release:** `cell_hit` asserts 3 cycles after `penirq_n` rises (2 synchroniser cycles + RELEASE). col/row are valid in the same cycle as `cell_hit`.
- **Reset mid-press:** takes effect immediately; no `cell_hit` or `write_slide` is issued.
- **Back-to-back presses:** fully supported; IDLE lasts ≥1 cycle between presses.

## Test plan
- **Tap:** DEB strobes at (45,30), then release → `cell_hit` one cycle with col=2, row=2; `drag`=0.
- **Drag:** press at (45,30), next strobe x=50 → `drag`=1; release → no `cell_hit`; col/row unchanged.
- **Bounce:** pen low for 2 strobes, then high → FSM returns to IDLE; `pen_down` never asserts; no outputs change.
- **Slider:** press at (130,160) → `slide_val`=63, `write_slide` pulses once; strobe x=250 → 127; strobe x=10 → 0.
- **Auto-repeat:** `slide_val`=125, hold + for 12 strobes → values 126 after the DEB-th strobe, 127 after 8 more, then no change and no further pulses.
- **Load priority / reset:** `load_en` with load_val=200 in the same cycle as a + step → `slide_val`=127, no `write_slide`. Assert iRST_n=0 mid-press → all outputs 0 and FSM in IDLE.
